// File: rtl/dm_arbiter.sv
// Shared data-memory arbiter: host has priority, cores are served round-robin
// while the system is in run phase. One DRAM access is in flight at a time.
module dm_arbiter #(
    parameter int NUM_CORES = 2,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    status,
    input  logic                          com_req,
    input  logic                          com_wr_en,
    input  logic [ADDR_W-1:0]             com_addr,
    input  logic [DATA_W-1:0]             com_data_in,
    output logic                          com_gnt,
    output logic                          com_rvalid,
    output logic [DATA_W-1:0]             com_data_out,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_wr_en,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]          core_gnt,
    output logic [NUM_CORES-1:0]          core_rvalid,
    output logic [DATA_W-1:0]             core_rdata,
    output logic [ADDR_W-1:0]             DM_addr,
    output logic [DATA_W-1:0]             DM_data_in,
    output logic                          DM_write_en,
    input  logic [DATA_W-1:0]             DM_out,
    output logic                          busy
);
    localparam int ID_W = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t                           state;
    logic [ID_W-1:0]                  rr_ptr;
    logic [ID_W-1:0]                  lat_id;
    logic                             lat_host;
    logic                             lat_wr;

    logic [NUM_CORES-1:0][ADDR_W-1:0] c_addr;
    logic [NUM_CORES-1:0][DATA_W-1:0] c_wdata;

    logic                             core_hit;
    logic [ID_W-1:0]                  core_win;
    logic [ID_W-1:0]                  cand;
    logic                             core_ok;

    assign c_addr  = core_addr;
    assign c_wdata = core_wdata;
    assign busy    = (state != IDLE);

    // Round-robin search: first requesting core after the last one served.
    always_comb begin
        core_hit = 1'b0;
        core_win = '0;
        cand     = '0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % NUM_CORES);
            if (!core_hit && core_req[cand]) begin
                core_hit = 1'b1;
                core_win = cand;
            end
        end
    end

    assign core_ok = (status == 2'b01) && core_hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= ID_W'(NUM_CORES - 1);
            lat_id       <= '0;
            lat_host     <= 1'b0;
            lat_wr       <= 1'b0;
            com_gnt      <= 1'b0;
            com_rvalid   <= 1'b0;
            com_data_out <= '0;
            core_gnt     <= '0;
            core_rvalid  <= '0;
            core_rdata   <= '0;
            DM_addr      <= '0;
            DM_data_in   <= '0;
            DM_write_en  <= 1'b0;
        end else begin
            com_gnt     <= 1'b0;
            core_gnt    <= '0;
            com_rvalid  <= 1'b0;
            core_rvalid <= '0;
            DM_write_en <= 1'b0;
            case (state)
                IDLE: begin
                    // DRAM drive is registered here so it is on the pins during ACCESS.
                    if (com_req) begin
                        lat_host    <= 1'b1;
                        lat_wr      <= com_wr_en;
                        DM_addr     <= com_addr;
                        DM_data_in  <= com_data_in;
                        DM_write_en <= com_wr_en;
                        com_gnt     <= 1'b1;
                        state       <= ACCESS;
                    end else if (core_ok) begin
                        lat_host           <= 1'b0;
                        lat_id             <= core_win;
                        lat_wr             <= core_wr_en[core_win];
                        DM_addr            <= c_addr[core_win];
                        DM_data_in         <= c_wdata[core_win];
                        DM_write_en        <= core_wr_en[core_win];
                        core_gnt[core_win] <= 1'b1;
                        state              <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (!lat_host)
                        rr_ptr <= lat_id;
                    state <= lat_wr ? IDLE : CAPTURE;
                end
                CAPTURE: begin
                    if (lat_host) begin
                        com_data_out <= DM_out;
                        com_rvalid   <= 1'b1;
                    end else begin
                        core_rdata          <= DM_out;
                        core_rvalid[lat_id] <= 1'b1;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Shared data-memory arbiter between the host communication port and the processor cores. It sits in front of one DRAM port and replaces the fixed host/core selector. Each cycle it can accept one request from the host or from one of `NUM_CORES` cores. It sequences the single-port DRAM access and returns read data with a valid pulse to the winning requester.

## Interface
Parameters:
- `NUM_CORES`, default 2: number of core requesters, 2..8.
- `DATA_W`, default 16: data width.
- `ADDR_W`, default 16: address width.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst_n`, in, 1: reset, synchronous, active-low.
- `status`, in, 2: system phase. 2'b01 is run; every other value is load/idle.
- `com_req`, in, 1: host access request.
- `com_wr_en`, in, 1: host write (1) or read (0).
- `com_addr`, in, ADDR_W: host address.
- `com_data_in`, in, DATA_W: host write data.
- `com_gnt`, out, 1: host request accepted (1-cycle pulse).
- `com_rvalid`, out, 1: `com_data_out` valid (1-cycle pulse).
- `com_data_out`, out, DATA_W: host read data.
- `core_req`, in, NUM_CORES: per-core request.
- `core_wr_en`, in, NUM_CORES: per-core write flag.
- `core_addr`, in, NUM_CORES*ADDR_W: packed addresses; core i at [i*ADDR_W +: ADDR_W].
- `core_wdata`, in, NUM_CORES*DATA_W: packed write data.
- `core_gnt`, out, NUM_CORES: one-hot grant pulse.
- `core_rvalid`, out, NUM_CORES: one-hot read-valid pulse.
- `core_rdata`, out, DATA_W: read data, shared by all cores and qualified by `core_rvalid`.
- `DM_addr`, out, ADDR_W: DRAM address.
- `DM_data_in`, out, DATA_W: DRAM write data.
- `DM_write_en`, out, 1: DRAM write strobe.
- `DM_out`, in, DATA_W: DRAM read data. It is registered and valid 1 cycle after the address.
- `busy`, out, 1: high whenever the state is not IDLE.

## Operation
- FSM has three states: IDLE, ACCESS, CAPTURE.

IDLE:
- Arbitration runs only in this state.
- Eligible requesters:
  - the host whenever `com_req` is 1;
  - cores only when `status == 2'b01`.
- Priority: host first, then cores in round-robin order.
- Round-robin search starts at `rr_ptr+1` modulo NUM_CORES and takes the first core with `core_req` set.
- On a winner:
  - latch its addr, wdata, wr_en and ID into internal registers;
  - go to ACCESS.
- With no winner, stay in IDLE.

ACCESS:
- Assert the winner's gnt for this cycle only.
- Drive `DM_addr` and `DM_data_in` from the latched registers.
- Write transaction: `DM_write_en` is 1 this cycle, then go to IDLE.
- Read transaction: `DM_write_en` is 0, then go to CAPTURE.
- If the winner is a core, `rr_ptr` updates to the winner ID. A host grant leaves `rr_ptr` unchanged.

CAPTURE:
- Register `DM_out` into `com_data_out` or `core_rdata`, according to the latched ID.
- Pulse the matching rvalid on the next cycle.
- Go to IDLE.

Outside ACCESS:
- `DM_write_en` is 0.
- `DM_addr` and `DM_data_in` hold their last driven values.

Requester rule:
- Hold req, addr, data and wr_en stable until gnt is sampled high.
- Deassert req on the edge that samples gnt, unless a new back-to-back request is intended.
- Requests are never dropped: an unserved req simply waits in IDLE.

A `status` change mid-transaction does not abort the transaction; the new value only affects the next IDLE arbitration.

## Timing
- Request sampled in IDLE at cycle T:
  - gnt and DRAM drive occur at T+1;
  - for reads, data is captured at T+2 and rvalid plus rdata appear at T+3.
- Write occupancy is 2 cycles (T, T+1). Read occupancy is 3 cycles (T, T+1, T+2).
- Read data registers (`com_data_out`, `core_rdata`) hold their value until the next read for that port.
- Reset values:
  - state IDLE;
  - `rr_ptr = NUM_CORES-1`, so core 0 wins first;
  - all gnt and rvalid 0;
  - `busy` 0;
  - `DM_write_en` 0;
  - `DM_addr`, `DM_data_in`, `com_data_out`, `core_rdata` all 0.
- Reset asserted in any state:
  - go to IDLE on that edge;
  - an in-flight write not yet in ACCESS is not issued;
  - a pending rvalid is suppressed.
- Host and cores requesting simultaneously: the host wins, and cores wait without losing their round-robin position.
- `rr_ptr` wraps from NUM_CORES-1 to 0.

## Test plan
- **Reset:** hold `rst_n=0` for 3 cycles with all reqs high. Required: every output 0; first grant 1 cycle after `rst_n` rises goes to host.
- **Host write/read, `status=2'b00`:**
  - host writes 0xBEEF to address 0x0010. Required: `DM_write_en` high 1 cycle with addr 0x0010 and data 0xBEEF.
  - host then reads 0x0010. Required: `com_rvalid` at T+3 with `com_data_out = 0xBEEF`.
- **Core gating:** `status=2'b00` with `core_req=2'b11`. Required: no `core_gnt` for 20 cycles. Switch to `status=2'b01`. Required: core0 granted, then core1.
- **Round-robin fairness:** `status=2'b01`, both cores continuously re-requesting writes. Required: grants alternate 0,1,0,1 over 8 transactions, one grant every 2 cycles.
- **Host priority:** core1 and host request in the same IDLE cycle. Required: host granted first; core1 granted in the next arbitration; `rr_ptr` unchanged by the host grant.
- **Reset mid-read:** assert `rst_n=0` in CAPTURE. Required: no rvalid pulse; `busy=0` next cycle; `core_rdata=0`.
